byte_to_bcd_scan: RTL and testbench

// - Upstream feeder for the 7-segment BCD decoder. Accepts an 8-bit binary value
//   (e.g. a received UART byte) over a valid/ready handshake.
// - Converts the value to 3 BCD digits with an iterative double-dabble, one shift per cycle.
// - Time-multiplexes the digits onto one 4-bit BCD bus with active-low digit enables.
// - bcd_digit[3] drives decoder input W, [2] drives X, [1] drives Y, [0] drives Z.

---
 rtl/byte_to_bcd_scan.sv | 166 ++++++++++++++++
 tb/tb_byte_to_bcd_scan.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_to_bcd_scan.sv
// byte_to_bcd_scan
// Accepts an 8-bit binary value over a valid/ready handshake and converts it
// to three BCD digits with an iterative double-dabble, one shift per clock.
// The latched result is time-multiplexed onto a single 4-bit BCD bus with
// active-low one-hot digit enables, feeding a 7-segment BCD decoder:
// bcd_digit[3] drives decoder input W, [2] X, [1] Y, [0] Z.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading-zero digits are blanked by holding their enable
//   high; the ones digit is never blanked so zero still shows as "0".
//   When undefined, all three digits are lit in turn.
module byte_to_bcd_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        busy,
  output logic [11:0] value_bcd,
  output logic [3:0]  bcd_digit,
  output logic [2:0]  an
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_cnt;
  logic [19:0]      r_shift;
  logic [11:0]      r_value;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic [3:0]       r_digit;
  logic [2:0]       r_an;

  logic             w_accept;
  logic             w_div_wrap;
  logic [1:0]       w_idx_nxt;
  logic [3:0]       w_digit_nxt;
  logic [2:0]       w_an_nxt;

  // Add-3 correction for one BCD nibble; applied before each shift so the
  // nibble carries into the next decade after the shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // One double-dabble iteration: correct all three BCD nibbles, then shift.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] c;
    c = {add3(s[19:16]), add3(s[15:12]), add3(s[11:8]), s[7:0]};
    return {c[18:0], 1'b0};
  endfunction

  // One-hot active-low enable pattern for a digit index.
  function automatic logic [2:0] idx_to_an(input logic [1:0] idx);
    logic [2:0] a;
    case (idx)
      2'd0:    a = 3'b110;
      2'd1:    a = 3'b101;
      2'd2:    a = 3'b011;
      default: a = 3'b110;
    endcase
    return a;
  endfunction

  assign w_accept  = din_valid && (r_state == S_IDLE);
  assign din_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign value_bcd = r_value;
  assign bcd_digit = r_digit;
  assign an        = r_an;

  // Conversion FSM: IDLE accepts, SHIFT runs eight dabble steps, DONE latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_value <= 12'h000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= 3'd0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_value <= r_shift[19:8];
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Shift register datapath; its contents are only meaningful while busy,
  // so it needs no reset (an aborted conversion never reaches DONE).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= {12'h000, din};
    end else if (r_state == S_SHIFT) begin
      r_shift <= dabble_step(r_shift);
    end
  end

  assign w_div_wrap = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_idx_nxt  = (r_idx == 2'd2) ? 2'd0 : (r_idx + 2'd1);

  // Select the nibble and enable pattern for the digit about to be shown.
  always_comb begin
    w_digit_nxt = 4'h0;
    case (w_idx_nxt)
      2'd0:    w_digit_nxt = r_value[3:0];
      2'd1:    w_digit_nxt = r_value[7:4];
      2'd2:    w_digit_nxt = r_value[11:8];
      default: w_digit_nxt = 4'h0;
    endcase
    w_an_nxt = idx_to_an(w_idx_nxt);
`ifdef LEADING_ZERO_BLANK_EN
    if (r_value[11:8] == 4'h0) begin
      w_an_nxt[2] = 1'b1;
    end
    if (r_value[11:4] == 8'h00) begin
      w_an_nxt[1] = 1'b1;
    end
`endif
  end

  // Free-running scan prescaler, independent of the conversion FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_div_wrap) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Digit index and registered bus/enables advance together on prescaler wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= 2'd0;
      r_digit <= 4'h0;
      r_an    <= 3'b110;
    end else if (w_div_wrap) begin
      r_idx   <= w_idx_nxt;
      r_digit <= w_digit_nxt;
      r_an    <= w_an_nxt;
    end
  end

endmodule

// File: tb/tb_byte_to_bcd_scan.sv
// Directed bench for byte_to_bcd_scan with a short scan divider.
module tb_byte_to_bcd_scan;

  logic        clk;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        busy;
  logic [11:0] value_bcd;
  logic [3:0]  bcd_digit;
  logic [2:0]  an;

  int n_checks;
  int n_fail;

  byte_to_bcd_scan #(.SCAN_DIV(4), .DIV_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .value_bcd (value_bcd),
    .bcd_digit (bcd_digit),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [2:0] exp_an(input int i, input logic [11:0] v);
    logic [2:0] a;
    case (i)
      0:       a = 3'b110;
      1:       a = 3'b101;
      default: a = 3'b011;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (v[11:8] == 4'h0) a[2] = 1'b1;
    if (v[11:4] == 8'h00) a[1] = 1'b1;
`endif
    return a;
  endfunction

  // Wait (bounded) for ready, present one value, return cycles until ready again.
  task automatic send(input logic [7:0] v, output int lat, output int nbusy);
    int n;
    n = 0;
    while (!din_ready && n < 50) begin
      tick();
      n++;
    end
    din       = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!din_ready && lat < 50) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, nb, n, lit, cyc, last, idx;
    logic [2:0]  prev;
    logic        was_ready;
    logic [11:0] v;
    logic [7:0]  t5_in [4];
    int          t5_lit [4];

    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    #1;
    tick();
    chk_eq("rst_ready", 32'(din_ready), 32'd1);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_value", 32'(value_bcd), 32'h000);
    chk_eq("rst_an", 32'(an), 32'b110);
    chk_eq("rst_digit", 32'(bcd_digit), 32'h0);
    rst = 1'b0;
    tick();

    // T1: 255, latency and busy width
    send(8'd255, lat, nb);
    chk_eq("t1_latency", 32'(lat), 32'd9);
    chk_eq("t1_busy_cycles", 32'(nb), 32'd9);
    chk_eq("t1_value", 32'(value_bcd), 32'h255);

    // T2: 7, scan sequence four cycles per digit
    send(8'd7, lat, nb);
    chk_eq("t2_value", 32'(value_bcd), 32'h007);
    n = 0;
    do begin
      prev = an;
      tick();
      n++;
    end while (!(an == 3'b110 && prev != 3'b110) && n < 40);
    chk_eq("t2_scan_sync", 32'(n < 40), 32'd1);
    for (int k = 0; k < 12; k++) begin
      chk_eq($sformatf("t2_an_%0d", k), 32'(an), 32'(exp_an((k / 4) % 3, 12'h007)));
      chk_eq($sformatf("t2_digit_%0d", k), 32'(bcd_digit),
             (((k / 4) % 3) == 0) ? 32'd7 : 32'd0);
      tick();
    end

    // T3: 128 then 99 with valid held, second accept at E10
    din       = 8'd128;
    din_valid = 1'b1;
    tick();
    din = 8'd99;
    for (int k = 1; k <= 9; k++) begin
      if (k == 9) chk_eq("t3_value_pre_e9", 32'(value_bcd), 32'h007);
      tick();
    end
    chk_eq("t3_value_128", 32'(value_bcd), 32'h128);
    chk_eq("t3_ready_e9", 32'(din_ready), 32'd1);
    tick();
    chk_eq("t3_accept_e10", 32'(busy), 32'd1);
    chk_eq("t3_ready_e10", 32'(din_ready), 32'd0);
    din_valid = 1'b0;
    for (int k = 11; k <= 19; k++) begin
      if (k == 19) chk_eq("t3_value_pre_e19", 32'(value_bcd), 32'h128);
      tick();
    end
    chk_eq("t3_value_099", 32'(value_bcd), 32'h099);

    // T4: reset after E4 of a 200 conversion
    din       = 8'd200;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("t4_value", 32'(value_bcd), 32'h000);
    chk_eq("t4_an", 32'(an), 32'b110);
    chk_eq("t4_ready", 32'(din_ready), 32'd1);
    chk_eq("t4_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 15; k++) tick();
    chk_eq("t4_value_later", 32'(value_bcd), 32'h000);

    // T5: values and lit-digit counts
    t5_in[0] = 8'd0;  t5_in[1] = 8'd100; t5_in[2] = 8'd99; t5_in[3] = 8'd10;
`ifdef LEADING_ZERO_BLANK_EN
    t5_lit[0] = 1; t5_lit[1] = 3; t5_lit[2] = 2; t5_lit[3] = 2;
`else
    t5_lit[0] = 3; t5_lit[1] = 3; t5_lit[2] = 3; t5_lit[3] = 3;
`endif
    for (int j = 0; j < 4; j++) begin
      send(t5_in[j], lat, nb);
      chk_eq($sformatf("t5_value_%0d", j), 32'(value_bcd), 32'(to_bcd(int'(t5_in[j]))));
      for (int k = 0; k < 12; k++) tick();
      lit = 0;
      for (int k = 0; k < 12; k++) begin
        lit = lit | int'(~an);
        tick();
      end
      chk_eq($sformatf("t5_lit_%0d", j), 32'($countones(lit[2:0])), 32'(t5_lit[j]));
    end

    // T6: exhaustive sweep with valid held
    idx       = 0;
    cyc       = 0;
    last      = -1;
    din       = 8'd0;
    din_valid = 1'b1;
    while (idx < 256 && cyc < 3000) begin
      was_ready = din_ready;
      tick();
      cyc++;
      if (was_ready) begin
        if (idx > 0) begin
          v = to_bcd(idx - 1);
          chk_eq($sformatf("t6_value_%0d", idx - 1), 32'(value_bcd), 32'(v));
          chk_eq($sformatf("t6_spacing_%0d", idx), 32'(cyc - last), 32'd10);
        end
        last = cyc;
        idx++;
        din = 8'(idx);
      end
    end
    din_valid = 1'b0;
    chk_eq("t6_all_accepted", 32'(idx), 32'd256);
    for (int k = 0; k < 9; k++) tick();
    chk_eq("t6_value_255", 32'(value_bcd), 32'h255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
